// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, op encodings and combinational helpers for dmem_sram.
// Load formatting, store byte enables/replication and access legality live here
// so the FSM in the top only sequences the access.
package dmem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam int DEFAULT_LATENCY = 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Extract and extend the addressed byte/half/word of a stored word.
  function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    r = {{24{b[7]}}, b};
      OP_BU:   r = {24'h0, b};
      OP_H:    r = {{16{h[15]}}, h};
      OP_HU:   r = {16'h0, h};
      OP_W:    r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_B:    be = 4'b0001 << lane;
      OP_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      OP_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across lanes; byte enables pick the lane.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    case (op)
      OP_B:    d = {4{wdata[7:0]}};
      OP_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Op/alignment legality; address range is checked separately.
  function automatic logic op_err(input logic [2:0] op, input logic wen, input logic [1:0] lane);
    logic e;
    case (op)
      OP_B:    e = 1'b0;
      OP_BU:   e = wen;
      OP_H:    e = lane[0];
      OP_HU:   e = wen | lane[0];
      OP_W:    e = (lane != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_lfsr.sv
// dmem_lfsr: 16-bit Galois LFSR, advanced every cycle, supplying 0..7 extra
// wait cycles. Only instantiated when DMEM_RAND_DELAY_EN is defined.
module dmem_lfsr
  import dmem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] delay_o
);

  logic [15:0] lfsr_q;

  // Shift right, folding the taps back in when the outgoing bit is set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
  end

  assign delay_o = lfsr_q[2:0];

endmodule

// File: rtl/dmem_sram.sv
// dmem_sram: data-memory slave for the core's Dmem port. One request at a time,
// access after a programmable latency, registered response with error flag.
// Optional macro DMEM_RAND_DELAY_EN adds 0..7 LFSR-driven extra wait cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request latched, counter runs down to 0, then array access
// RESP  | resp_valid high with outputs held until resp_ready
module dmem_sram
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = 5;  // holds 14 + 7 with random delay
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY - 1);
  localparam logic [32:0] LIMIT    = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  dmem_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic [31:0]   addr_q, wdata_q;
  logic          wen_q;
  logic [2:0]    op_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [2:0]    extra_w;
  logic [AW-1:0] idx_w;
  logic          oor_w, acc_err_w, at_tc_w, mem_we_w;
  logic [3:0]    be_w;
  logic [31:0]   wd_w, rd_word_w;

`ifdef DMEM_RAND_DELAY_EN
  dmem_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .delay_o (extra_w)
  );
`else
  assign extra_w = 3'd0;
`endif

  assign idx_w     = AW'((addr_q - ADDR_BASE) >> 2);
  assign oor_w     = (addr_q < ADDR_BASE) || ({1'b0, addr_q} >= LIMIT);
  assign acc_err_w = oor_w | op_err(op_q, wen_q, addr_q[1:0]);
  assign at_tc_w   = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we_w  = at_tc_w && wen_q && !acc_err_w;
  assign be_w      = store_be(op_q, addr_q[1:0]);
  assign wd_w      = store_data(op_q, wdata_q);
  assign rd_word_w = mem_q[idx_w];

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wen_q        <= 1'b0;
      op_q         <= 3'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wen_q       <= req_wen;
            op_q        <= req_op;
            cnt_q       <= LAT_LOAD + CW'(extra_w);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err_w;
            resp_rdata_q <= (acc_err_w || wen_q) ? 32'h0 : load_fmt(op_q, addr_q[1:0], rd_word_w);
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array write at the terminal count; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we_w) begin
      for (int b = 0; b < 4; b++)
        if (be_w[b]) mem_q[idx_w][8*b +: 8] <= wd_w[8*b +: 8];
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
